// File: rtl/icache_param.sv
// Direct-mapped instruction cache with multi-word blocks, burst fill, whole-cache flush
// and saturating hit/miss counters.
module icache_param #(
   parameter int unsigned SETS  = 16,
   parameter int unsigned WORDS = 2,
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   input  logic             flush,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int unsigned OFF_W = $clog2(WORDS);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
   localparam int unsigned CW    = (OFF_W == 0) ? 1 : OFF_W;
   localparam int unsigned DA_W  = $clog2(SETS * WORDS);

   typedef enum logic {IDLE, FILL} state_t;

   state_t           state;
   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tag_arr [SETS];
   logic [31:0]      data_arr [SETS*WORDS];

   logic [TAG_W-1:0] req_tag, lat_tag;
   logic [IDX_W-1:0] req_idx, lat_idx;
   logic [CW-1:0]    req_off, cnt;
   logic [DA_W-1:0]  rd_addr, wr_addr;
   logic             hit_c, last_c;

   function automatic logic [31:0] fill_addr(input logic [TAG_W-1:0] t,
                                             input logic [IDX_W-1:0] i,
                                             input logic [CW-1:0] c);
      return (32'(t) << (2 + OFF_W + IDX_W)) | (32'(i) << (2 + OFF_W)) | (32'(c) << 2);
   endfunction

   // Address decode of the current fetch
   assign req_off = CW'((imemaddr >> 2) & 32'(WORDS - 1));
   assign req_idx = IDX_W'(imemaddr >> (2 + OFF_W));
   assign req_tag = TAG_W'(imemaddr >> (2 + OFF_W + IDX_W));
   assign rd_addr = DA_W'(32'(req_idx) * WORDS + 32'(req_off));
   assign wr_addr = DA_W'(32'(lat_idx) * WORDS + 32'(cnt));
   assign last_c  = (cnt == CW'(WORDS - 1));

   // Hit depends only on registered state and fetch inputs, never on iwait/iload
   assign hit_c    = (state == IDLE) && imemREN && !flush && valid[req_idx] &&
                     (tag_arr[req_idx] == req_tag);
   assign ihit     = hit_c;
   assign imemload = data_arr[rd_addr];

   // Tag and data storage; not reset, guarded by the valid bits
   always_ff @(posedge CLK) begin
      if (state == FILL && !iwait) begin
         data_arr[wr_addr] <= iload;
         if (last_c) tag_arr[lat_idx] <= lat_tag;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         valid    <= '0;
         cnt      <= '0;
         lat_tag  <= '0;
         lat_idx  <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
         iREN     <= 1'b0;
         iaddr    <= '0;
      end else begin
         if (hit_c && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               if (flush) begin
                  valid <= '0;
               end else if (imemREN && !hit_c) begin
                  lat_tag <= req_tag;
                  lat_idx <= req_idx;
                  cnt     <= '0;
                  state   <= FILL;
                  iREN    <= 1'b1;
                  iaddr   <= fill_addr(req_tag, req_idx, '0);
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
               end
            end
            FILL: begin
               // Flush beats completion: the block is abandoned and every set invalidated
               if (flush) begin
                  valid <= '0;
                  cnt   <= '0;
                  state <= IDLE;
                  iREN  <= 1'b0;
                  iaddr <= '0;
               end else if (!iwait) begin
                  if (last_c) begin
                     valid[lat_idx] <= 1'b1;
                     cnt            <= '0;
                     state          <= IDLE;
                     iREN           <= 1'b0;
                     iaddr          <= '0;
                  end else begin
                     cnt   <= cnt + CW'(1);
                     iaddr <= fill_addr(lat_tag, lat_idx, cnt + CW'(1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_param.sv
// Bench for icache_param: fetch vector table against a wait-state memory model,
// plus hand sequences for flush, saturation and reset during a fill.
module tb_icache_param;

   localparam int unsigned SETS  = 16;
   localparam int unsigned WORDS = 2;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LAT   = 1;

   logic             CLK, RST, imemREN, flush, iwait;
   logic [31:0]      imemaddr, imemload, iaddr, iload;
   logic             ihit, iREN;
   logic [CNT_W-1:0] hit_cnt, miss_cnt;

   icache_param #(.SETS(SETS), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
      .imemload(imemload), .flush(flush), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
      .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] beats[$];
   logic [CNT_W-1:0] exp_hits, exp_miss;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + CNT_W'(1);
   endfunction

   // Memory: LAT wait cycles before each word is returned
   logic [31:0] cur;
   bit          pend;
   int          left;
   initial begin
      iwait = 1'b1; iload = '0; pend = 0; left = 0; cur = '0;
   end
   always @(negedge CLK) begin
      if (!iREN) begin
         pend  = 0;
         iwait = 1'b1;
      end else begin
         if (!pend || iaddr != cur) begin
            pend = 1; cur = iaddr; left = LAT;
         end
         iwait = (left != 0);
         if (left != 0) left--;
      end
      iload = mem_word(iaddr);
   end

   always @(posedge CLK) if (!RST && iREN && !iwait) beats.push_back(iaddr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] a, input bit miss, input string name);
      int cyc;
      logic [31:0] e, base;
      base = a & ~32'(WORDS * 4 - 1);
      beats.delete();
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = a;
      exp_q.push_back(mem_word(a & ~32'h3));
      cyc = 0;
      #1;
      while (!ihit && cyc < 100) begin
         @(negedge CLK); #1; cyc++;
      end
      check({name, " latency"}, 32'(cyc), miss ? 32'(1 + WORDS * (LAT + 1)) : 32'd0);
      e = exp_q.pop_front();
      if (ihit) begin
         check({name, " data"}, imemload, e);
         exp_hits = sat(exp_hits);
      end
      if (miss) begin
         exp_miss = sat(exp_miss);
         check({name, " beats"}, 32'(beats.size()), 32'(WORDS));
         for (int w = 0; w < beats.size() && w < int'(WORDS); w++)
            check({name, " iaddr"}, beats[w], base + 32'(4 * w));
      end else begin
         check({name, " no_fill"}, 32'(beats.size()), 32'd0);
      end
      @(negedge CLK);
      imemREN = 1'b0;
      #1;
      check({name, " hit_cnt"}, 32'(hit_cnt), 32'(exp_hits));
      check({name, " miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
   endtask

   typedef struct {
      logic [31:0] addr;
      bit          miss;
      string       name;
   } vec_t;

   vec_t vecs[10];
   bit   found;

   initial begin
      vecs[0] = '{32'h0000_0040, 1'b1, "cold_miss"};
      vecs[1] = '{32'h0000_0044, 1'b0, "spatial_hit"};
      vecs[2] = '{32'h0000_0140, 1'b1, "conflict_new_tag"};
      vecs[3] = '{32'h0000_0040, 1'b1, "conflict_back"};
      vecs[4] = '{32'h0000_0048, 1'b1, "next_set"};
      vecs[5] = '{32'h0000_004C, 1'b0, "next_set_word1"};
      vecs[6] = '{32'h0000_0044, 1'b0, "first_set_kept"};
      vecs[7] = '{32'h8000_0040, 1'b1, "high_tag"};
      vecs[8] = '{32'h0000_0048, 1'b0, "other_set_kept"};
      vecs[9] = '{32'h0000_0000, 1'b1, "set0"};

      imemREN = 1'b0; imemaddr = '0; flush = 1'b0; RST = 1'b1;
      exp_hits = '0; exp_miss = '0;
      repeat (3) @(negedge CLK);
      #1;
      check("reset ihit", 32'(ihit), 32'd0);
      check("reset iREN", 32'(iREN), 32'd0);
      check("reset iaddr", iaddr, 32'd0);
      check("reset hit_cnt", 32'(hit_cnt), 32'd0);
      check("reset miss_cnt", 32'(miss_cnt), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 10; i++) fetch(vecs[i].addr, vecs[i].miss, vecs[i].name);

      // Flush in IDLE masks a would-be hit and invalidates everything
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h48; flush = 1'b1;
      #1;
      check("flush_forces_ihit_low", 32'(ihit), 32'd0);
      @(negedge CLK);
      imemREN = 1'b0; flush = 1'b0;
      fetch(32'h48, 1'b1, "after_idle_flush");

      // Flush in the first FILL cycle aborts the fill
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h200;
      @(negedge CLK);
      flush = 1'b1; imemREN = 1'b0;
      #1;
      check("fill_started", 32'(iREN), 32'd1);
      exp_miss = sat(exp_miss);
      @(negedge CLK);
      flush = 1'b0;
      #1;
      check("flush_abort_iREN", 32'(iREN), 32'd0);
      check("flush_abort_miss_cnt", 32'(miss_cnt), 32'(exp_miss));
      fetch(32'h200, 1'b1, "refetch_after_abort");
      fetch(32'h48, 1'b1, "fill_flush_clears_all");

      // Flush coinciding with the final beat leaves the block invalid
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h300;
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge CLK); #1;
         if (iREN && !iwait && iaddr == 32'h304) begin
            flush = 1'b1; found = 1;
         end
      end
      check("flush_last_beat_seen", 32'(found), 32'd1);
      exp_miss = sat(exp_miss);
      @(negedge CLK);
      flush = 1'b0; imemREN = 1'b0;
      #1;
      check("flush_complete_iREN", 32'(iREN), 32'd0);
      fetch(32'h300, 1'b1, "flush_with_completion");

      // Hold a hit for 20 cycles: hit counter saturates
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h300;
      for (int k = 0; k < 20; k++) begin
         exp_hits = sat(exp_hits);
         @(negedge CLK);
      end
      imemREN = 1'b0;
      #1;
      check("hit_cnt_saturated", 32'(hit_cnt), 32'd15);
      check("hit_cnt_model", 32'(hit_cnt), 32'(exp_hits));

      // Reset during FILL
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h500;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("fill_before_reset", 32'(iREN), 32'd1);
      @(negedge CLK);
      RST = 1'b0; imemREN = 1'b0;
      #1;
      check("reset_fill iREN", 32'(iREN), 32'd0);
      check("reset_fill iaddr", iaddr, 32'd0);
      check("reset_fill hit_cnt", 32'(hit_cnt), 32'd0);
      check("reset_fill miss_cnt", 32'(miss_cnt), 32'd0);
      exp_hits = '0; exp_miss = '0;
      fetch(32'h500, 1'b1, "refill_after_reset");
      fetch(32'h300, 1'b1, "reset_cleared_valid");

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
